// File: rtl/if_pkg.sv
// Shared constants and the default queue entry type for the instruction-fetch front end.
package if_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int PC_INC      = 4;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_queue_chk.sv
// Invariants of the fetch credit scheme; any firing indicates a design error.
module if_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] out_cnt,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] occ,
    input logic          push,
    input logic          full,
    input logic          rsp_valid
);

    a_out_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) out_cnt <= CW'(DEPTH));
    a_occ_max:     assert property (@(posedge clk) disable iff (!rst_n) occ <= CW'(DEPTH));
    a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= out_cnt);
    a_push_full:   assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_rsp_owed:    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_valid && out_cnt == {CW{1'b0}}));

endmodule

// File: rtl/if_instr_fifo.sv
// Synchronous FIFO of fetched entries; flush empties it in one cycle and wins over push/pop.
module if_instr_fifo
    import if_pkg::*;
#(
    parameter type entry_t = if_entry_t,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        push_data,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC-sequential requests with bounded credits, a prefetch queue
// toward decode, and redirect handling that drops responses still in flight.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_src,
    input  logic [PC_W-1:0]    dest_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               valid_D,
    input  logic               ready_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [PC_W-1:0]    pc_D,
    output logic [PC_W-1:0]    pc_plus4_D
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    logic [PC_W-1:0] fetch_pc_r;
    logic [PC_W-1:0] rsp_pc_r;
    logic [CW-1:0]   out_cnt_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   occ_s;
    logic [CW:0]     credit_s;
    logic [PC_W-1:0] target_s;
    logic            req_ok_s;
    logic            req_fire_s;
    logic            rsp_drop_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    fq_entry_t       push_entry_s;
    fq_entry_t       head_s;

    // Request credit: never let queued plus live in-flight entries exceed the queue size.
    always_comb begin
        target_s   = dest_pc & ~PC_W'(2'b11);
        credit_s   = {1'b0, occ_s} + {1'b0, out_cnt_r} - {1'b0, drop_cnt_r};
        req_ok_s   = !pc_src && (out_cnt_r < CW'(DEPTH)) && (credit_s < (CW+1)'(DEPTH));
        req_fire_s = reset && req_ok_s && imem_req_ready;
        rsp_drop_s = (drop_cnt_r != {CW{1'b0}});
        push_s     = imem_rsp_valid && !rsp_drop_s && !pc_src;
        pop_s      = valid_D && ready_D && !pc_src;
        push_entry_s.pc    = rsp_pc_r;
        push_entry_s.instr = imem_rsp_data;
    end

    assign imem_req_valid = reset && req_ok_s;
    assign imem_addr      = fetch_pc_r;
    assign valid_D        = !fifo_empty_s;

    // Fetch PC, response PC and the outstanding/drop counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            out_cnt_r  <= {CW{1'b0}};
            drop_cnt_r <= {CW{1'b0}};
        end else begin
            out_cnt_r <= out_cnt_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
            if (pc_src) begin
                fetch_pc_r <= target_s;
                rsp_pc_r   <= target_s;
                drop_cnt_r <= out_cnt_r - CW'(imem_rsp_valid);
            end else begin
                if (req_fire_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
                if (imem_rsp_valid && rsp_drop_s)  drop_cnt_r <= drop_cnt_r - CW'(1);
                if (imem_rsp_valid && !rsp_drop_s) rsp_pc_r   <= rsp_pc_r + PC_STEP;
            end
        end
    end

    // Decode-side view of the head entry; zero whenever nothing is presented.
    always_comb begin
        if (valid_D) begin
            instr_D    = head_s.instr;
            pc_D       = head_s.pc;
            pc_plus4_D = head_s.pc + PC_STEP;
        end else begin
            instr_D    = {INSTR_W{1'b0}};
            pc_D       = {PC_W{1'b0}};
            pc_plus4_D = {PC_W{1'b0}};
        end
    end

    if_instr_fifo #(
        .entry_t (fq_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (pc_src),
        .push_data (push_entry_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (occ_s)
    );

    if_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (reset),
        .out_cnt   (out_cnt_r),
        .drop_cnt  (drop_cnt_r),
        .occ       (occ_s),
        .push      (push_s),
        .full      (fifo_full_s),
        .rsp_valid (imem_rsp_valid)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue/in-flight reference model checked every cycle, plus literal pins.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src;
    logic [15:0] dest_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_D, ready_D;
    logic [31:0] instr_D;
    logic [15:0] pc_D, pc_plus4_D;

    logic        req_valid8, rsp_valid8, valid8;
    logic [7:0]  addr8, pc8, pc_plus4_8;
    logic [31:0] rsp_data8, instr8;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] addr; bit stale; } fl_t;
    typedef struct { logic [15:0] pc; logic [31:0] instr; } me_t;
    fl_t         infl[$];
    me_t         mq[$];
    logic [15:0] m_fetch_pc;
    bit          mem_stall;
    bit          rsp_v;
    bit          exp_req;
    bit          exp_valid;
    logic        fire8_prev;
    logic [7:0]  addr8_prev;

    always #5 clk = ~clk;

    if_fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(rst_n), .pc_src(pc_src), .dest_pc(dest_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .valid_D(valid_D), .ready_D(ready_D), .instr_D(instr_D), .pc_D(pc_D), .pc_plus4_D(pc_plus4_D)
    );

    if_fetch_queue #(.PC_W(8), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(8'hFC)) dut8 (
        .clk(clk), .reset(rst_n), .pc_src(1'b0), .dest_pc(8'h00),
        .imem_req_valid(req_valid8), .imem_req_ready(1'b1), .imem_addr(addr8),
        .imem_rsp_valid(rsp_valid8), .imem_rsp_data(rsp_data8),
        .valid_D(valid8), .ready_D(1'b1), .instr_D(instr8), .pc_D(pc8), .pc_plus4_D(pc_plus4_8)
    );

    function automatic logic [31:0] instr_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        mq.delete();
        infl.delete();
        m_fetch_pc = 16'h0000;
        fire8_prev = 1'b0;
        addr8_prev = 8'h00;
    endfunction

    // Called at a falling edge: drive memory responses, settle, compare against the model.
    task automatic drive_check();
        int live;
        rsp_v          = !mem_stall && (infl.size() > 0);
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? instr_of(infl[0].addr) : 32'h0;
        rsp_valid8     = fire8_prev;
        rsp_data8      = instr_of({8'h00, addr8_prev});
        #1;
        live = 0;
        foreach (infl[i]) if (!infl[i].stale) live++;
        exp_req   = !pc_src && (infl.size() < DEPTH) && (mq.size() + live < DEPTH);
        exp_valid = (mq.size() != 0);
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_fetch_pc});
        chk("valid_D", {31'd0, valid_D}, {31'd0, exp_valid});
        chk("pc_D", {16'd0, pc_D}, exp_valid ? {16'd0, mq[0].pc} : 32'd0);
        chk("pc_plus4_D", {16'd0, pc_plus4_D}, exp_valid ? {16'd0, mq[0].pc + 16'd4} : 32'd0);
        chk("instr_D", instr_D, exp_valid ? mq[0].instr : 32'd0);
    endtask

    // Apply this cycle's effects to the model, then move to the next falling edge.
    task automatic advance();
        fl_t f;
        fire8_prev = req_valid8;
        addr8_prev = addr8;
        if (!pc_src && exp_valid && ready_D) void'(mq.pop_front());
        if (rsp_v) begin
            f = infl.pop_front();
            if (!f.stale && !pc_src) mq.push_back('{pc: f.addr, instr: instr_of(f.addr)});
        end
        if (pc_src) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_fetch_pc = dest_pc & 16'hFFFC;
        end else if (exp_req && imem_req_ready) begin
            infl.push_back('{addr: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 16'd4;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        drive_check();
        advance();
    endtask

    task automatic wait_head(input string name, input logic [15:0] exp_pc);
        int n = 0;
        drive_check();
        while (!valid_D && n < 20) begin
            advance();
            drive_check();
            n++;
        end
        chk({name, "_seen"}, {31'd0, valid_D}, 32'd1);
        chk({name, "_pc"}, {16'd0, pc_D}, {16'd0, exp_pc});
        advance();
    endtask

    task automatic reset_pins(input string name);
        chk({name, "_valid"}, {31'd0, valid_D}, 32'd0);
        chk({name, "_req"}, {31'd0, imem_req_valid}, 32'd0);
        chk({name, "_pc"}, {16'd0, pc_D}, 32'd0);
        chk({name, "_pc4"}, {16'd0, pc_plus4_D}, 32'd0);
        chk({name, "_instr"}, instr_D, 32'd0);
        chk({name, "_valid8"}, {31'd0, valid8}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pc_src = 1'b0; dest_pc = 16'h0000; ready_D = 1'b0;
        imem_req_ready = 1'b1; mem_stall = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        rsp_valid8 = 1'b0; rsp_data8 = 32'h0;
        reset_model();
        @(negedge clk);
        #1 reset_pins("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Hold decode off: queue fills, head pinned at 0x0.
        drive_check();
        chk("c0_addr", {16'd0, imem_addr}, 32'h0000);
        chk("c0_req", {31'd0, imem_req_valid}, 32'd1);
        chk("w8_c0_addr", {24'd0, addr8}, 32'h00FC);
        advance();
        drive_check();
        chk("c1_addr", {16'd0, imem_addr}, 32'h0004);
        chk("c1_valid", {31'd0, valid_D}, 32'd0);
        chk("w8_c1_addr", {24'd0, addr8}, 32'h0000);
        advance();
        drive_check();
        chk("c2_valid", {31'd0, valid_D}, 32'd1);
        chk("c2_pc", {16'd0, pc_D}, 32'h0000);
        chk("c2_pc4", {16'd0, pc_plus4_D}, 32'h0004);
        chk("w8_c2_pc", {24'd0, pc8}, 32'h00FC);
        chk("w8_c2_pc4", {24'd0, pc_plus4_8}, 32'h0000);
        chk("w8_c2_instr", instr8, instr_of(16'h00FC));
        advance();
        for (int i = 3; i < 9; i++) cycle();
        drive_check();
        chk("full_req", {31'd0, imem_req_valid}, 32'd0);
        chk("full_pc", {16'd0, pc_D}, 32'h0000);
        advance();

        // Release: four in-order dequeues.
        ready_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_check();
            chk("drain_pc", {16'd0, pc_D}, 32'(i * 4));
            advance();
        end
        for (int i = 0; i < 6; i++) cycle();

        // Redirect to 0x40 while memory holds responses back.
        mem_stall = 1'b1;
        cycle();
        cycle();
        pc_src = 1'b1; dest_pc = 16'h0040;
        cycle();
        pc_src = 1'b0; mem_stall = 1'b0;
        wait_head("redir40", 16'h0040);
        for (int i = 0; i < 6; i++) cycle();

        // Redirect coinciding with a live response; target low bits ignored.
        pc_src = 1'b1; dest_pc = 16'h0023;
        cycle();
        pc_src = 1'b0;
        drive_check();
        chk("redir23_addr", {16'd0, imem_addr}, 32'h0020);
        chk("redir23_req", {31'd0, imem_req_valid}, 32'd1);
        advance();
        wait_head("redir23", 16'h0020);

        // Mixed stalls, grant gaps and redirects.
        for (int i = 0; i < 150; i++) begin
            ready_D        = ((i % 3) != 2);
            imem_req_ready = ((i % 5) != 1);
            mem_stall      = ((i % 7) == 3);
            pc_src         = ((i % 29) == 11);
            dest_pc        = 16'(i * 52 + 3);
            cycle();
        end
        pc_src = 1'b0; mem_stall = 1'b0; imem_req_ready = 1'b1;

        // Asynchronous reset with the queue partly full.
        ready_D = 1'b0;
        cycle();
        cycle();
        cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0; rsp_valid8 = 1'b0;
        reset_model();
        #1 reset_pins("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        drive_check();
        chk("post_rst_addr", {16'd0, imem_addr}, 32'h0000);
        chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
        advance();
        ready_D = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
